// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline registers: word size, EX/MEM bundle layout
// and the occupancy-state encoding used by pipe_stage_reg.
package pipe_pkg;

    localparam int XLEN = 32;

    // Field positions inside the packed EX/MEM bundle
    localparam int FLD_ALU_OUT  = 0;
    localparam int FLD_RS2      = 1;
    localparam int EXMEM_FIELDS = 2;
    localparam int EXMEM_W      = EXMEM_FIELDS * XLEN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One W-bit storage entry of a pipeline stage.
// Loads on enable and clears asynchronously.
module pipe_skid_entry #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register carrying NUM_FIELDS packed fields, with synchronous flush.
// The optional skid entry lets in_ready come from a flop instead of from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int NUM_FIELDS = 2,
    parameter int SKID       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                   occupancy
);

    localparam int W = NUM_FIELDS * DATA_W;

    stage_state_e state_q, state_d;
    logic         in_ready_q;
    logic         accept, emit;
    logic         load_main, load_skid, main_from_skid;
    logic [W-1:0] main_d, skid_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        if (emit || (SKID == 0)) begin
                            load_main = 1'b1;
                        end else begin
                            load_skid = 1'b1;
                            state_d   = ST_SKID;
                        end
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d        = ST_FULL;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // Registered ready: looks ahead at whether the skid entry will be occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            in_ready_q <= 1'b1;
        else
            in_ready_q <= (state_d != ST_SKID);
    end

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_skid_entry #(.W(W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_skid_entry #(.W(W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg, built once with a skid entry and once without.
module tb_pipe_stage_reg;

    logic        clk, rst;
    logic        v1, rdy1, ov1, r1, f1;
    logic [63:0] d1, od1;
    logic [1:0]  occ1;
    logic        v0, rdy0, ov0, r0, f0;
    logic [63:0] d0, od0;
    logic [1:0]  occ0;

    int checks = 0;
    int errors = 0;

    logic [63:0] q1[$];
    logic [63:0] q0[$];

    pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(2), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(f1),
        .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(2), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(f0),
        .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .out_valid(ov0), .out_ready(r0), .out_data(od0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r, input logic f);
        v1 = v;
        d1 = d;
        r1 = r;
        f1 = f;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word(input int k);
        logic [31:0] hi, lo;
        hi = 32'h0000_0002 + 32'(k);
        lo = 32'hDEAD_BEEF + 32'(k);
        return {hi, lo};
    endfunction

    initial begin
        logic        mv;
        logic [63:0] md;
        logic        exp_rdy;
        int          n;
        int          emitted;

        rst = 1'b1;
        v1 = 0; d1 = '0; r1 = 0; f1 = 0;
        v0 = 0; d0 = '0; r0 = 0; f0 = 0;
        #12;
        checkOutput("rst_out_valid", 64'(ov1), 64'd0);
        checkOutput("rst_out_data", od1, 64'd0);
        checkOutput("rst_occupancy", 64'(occ1), 64'd0);
        checkOutput("rst_in_ready", 64'(rdy1), 64'd1);
        checkOutput("rst_in_ready_noskid", 64'(rdy0), 64'd1);
        rst = 1'b0;
        nextEdge();

        $display("[TB] stream after reset");
        applyStimulus(1'b1, word(0), 1'b1, 1'b0);
        checkOutput("stream_latency", 64'(ov1), 64'd0);
        for (int k = 0; k < 4; k++) begin
            nextEdge();
            checkOutput("stream_valid", 64'(ov1), 64'd1);
            checkOutput("stream_data", od1, word(k));
            checkOutput("stream_occ", 64'(occ1), 64'd1);
            checkOutput("stream_ready", 64'(rdy1), 64'd1);
            applyStimulus(k < 3, word(k + 1), 1'b1, 1'b0);
        end
        nextEdge();
        checkOutput("stream_drain_valid", 64'(ov1), 64'd0);
        checkOutput("stream_drain_occ", 64'(occ1), 64'd0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
        nextEdge();
        applyStimulus(1'b1, 64'h22, 1'b0, 1'b0);
        nextEdge();
        checkOutput("bp_occ_full", 64'(occ1), 64'd2);
        checkOutput("bp_ready_low", 64'(rdy1), 64'd0);
        checkOutput("bp_data_a", od1, 64'h11);
        applyStimulus(1'b1, 64'h33, 1'b0, 1'b0);
        nextEdge();
        checkOutput("bp_hold_occ", 64'(occ1), 64'd2);
        checkOutput("bp_hold_ready", 64'(rdy1), 64'd0);
        checkOutput("bp_hold_data", od1, 64'h11);
        applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
        nextEdge();
        checkOutput("bp_data_b", od1, 64'h22);
        checkOutput("bp_occ_one", 64'(occ1), 64'd1);
        checkOutput("bp_ready_back", 64'(rdy1), 64'd1);
        applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
        nextEdge();
        checkOutput("bp_data_c", od1, 64'h33);
        checkOutput("bp_valid_c", 64'(ov1), 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("bp_empty", 64'(ov1), 64'd0);

        $display("[TB] flush with simultaneous accept");
        applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
        nextEdge();
        checkOutput("flush_pre_valid", 64'(ov1), 64'd1);
        applyStimulus(1'b1, 64'h44, 1'b0, 1'b1);
        nextEdge();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("flush_valid", 64'(ov1), 64'd0);
        checkOutput("flush_occ", 64'(occ1), 64'd0);
        checkOutput("flush_ready", 64'(rdy1), 64'd1);
        checkOutput("flush_data_kept", od1, 64'h11);
        nextEdge();
        checkOutput("flush_no_d_valid", 64'(ov1), 64'd0);
        checkOutput("flush_no_d_data", od1, 64'h11);

        $display("[TB] async reset while skidded");
        applyStimulus(1'b1, 64'h55, 1'b0, 1'b0);
        nextEdge();
        applyStimulus(1'b1, 64'h66, 1'b0, 1'b0);
        nextEdge();
        checkOutput("areset_pre_occ", 64'(occ1), 64'd2);
        #3 rst = 1'b1;
        #1;
        checkOutput("areset_valid", 64'(ov1), 64'd0);
        checkOutput("areset_data", od1, 64'd0);
        checkOutput("areset_occ", 64'(occ1), 64'd0);
        checkOutput("areset_ready", 64'(rdy1), 64'd1);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        nextEdge();

        $display("[TB] single-entry build with toggling ready");
        mv = 1'b0;
        md = '0;
        n  = 0;
        for (int i = 0; i < 8; i++) begin
            v0 = 1'b1;
            d0 = 64'hA000_0000_0000_0000 + 64'(n);
            r0 = (i % 2 == 0);
            #1;
            exp_rdy = ~mv | r0;
            checkOutput("ns_ready", 64'(rdy0), 64'(exp_rdy));
            checkOutput("ns_valid", 64'(ov0), 64'(mv));
            checkOutput("ns_occ", 64'(occ0), 64'(mv));
            checkOutput("ns_data", od0, md);
            if (exp_rdy) begin
                md = d0;
                mv = 1'b1;
                n++;
            end else if (mv & r0) begin
                mv = 1'b0;
            end
            nextEdge();
        end
        v0 = 1'b0;
        r0 = 1'b1;
        nextEdge();
        nextEdge();

        $display("[TB] random valid/ready against scoreboard");
        emitted = 0;
        for (int i = 0; i < 4000; i++) begin
            v1 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            d1 = {$urandom, $urandom};
            v0 = ($urandom_range(0, 3) != 0);
            r0 = ($urandom_range(0, 2) != 0);
            d0 = {$urandom, $urandom};
            #1;
            checkOutput("rnd_occ", 64'(occ1), 64'(q1.size()));
            checkOutput("rnd_valid", 64'(ov1), 64'(q1.size() > 0));
            checkOutput("rnd_ready", 64'(rdy1), 64'(q1.size() < 2));
            checkOutput("rnd_ns_occ", 64'(occ0), 64'(q0.size()));
            checkOutput("rnd_ns_ready", 64'(rdy0), 64'((q0.size() == 0) | r0));
            if (ov1 && r1 && q1.size() > 0) begin
                checkOutput("rnd_data", od1, q1[0]);
                void'(q1.pop_front());
                emitted++;
            end
            if (v1 && rdy1)
                q1.push_back(d1);
            if (ov0 && r0 && q0.size() > 0) begin
                checkOutput("rnd_ns_data", od0, q0[0]);
                void'(q0.pop_front());
            end
            if (v0 && rdy0)
                q0.push_back(d0);
            nextEdge();
        end
        checkOutput("rnd_progress", 64'(emitted > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
